// File: rtl/if_id_fetch_buffer_pkg.sv
// Shared core definitions for the fetch/decode boundary.
package if_id_fetch_buffer_pkg;

    localparam logic [31:0] FB_NOP           = 32'h0000_0013;  // addi x0,x0,0
    localparam int          FB_DEFAULT_DEPTH = 4;

    // Fetched instruction with its PC; decode consumes the same layout.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/if_id_fetch_buffer_if.sv
// Fetch-side and decode-side signals of the IF/ID fetch buffer.
interface if_id_fetch_buffer_if
    import if_id_fetch_buffer_pkg::*;
#(
    parameter int DEPTH = FB_DEFAULT_DEPTH
);
    logic                     if_flush;
    logic [31:0]              if_inst;
    logic [31:0]              if_pc;
    logic                     pc_stall;
    logic                     id_valid;
    logic [31:0]              id_inst;
    logic [31:0]              id_pc;
    logic                     id_ready;
    logic [$clog2(DEPTH):0]   fb_count;

    modport master (
        output if_flush, if_inst, if_pc, id_ready,
        input  pc_stall, id_valid, id_inst, id_pc, fb_count
    );

    modport slave (
        input  if_flush, if_inst, if_pc, id_ready,
        output pc_stall, id_valid, id_inst, id_pc, fb_count
    );
endinterface

// File: rtl/if_id_fetch_buffer.sv
// Fetch-to-decode FIFO: queues {pc, inst} pairs, throttles fetch via pc_stall
// so the in-flight ROM read always has a slot, and drops everything on flush.
module if_id_fetch_buffer
    import if_id_fetch_buffer_pkg::*;
#(
    parameter int          DEPTH = FB_DEFAULT_DEPTH,
    parameter logic [31:0] NOP   = FB_NOP
) (
    input  logic                 clk,
    input  logic                 rstn,
    if_id_fetch_buffer_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t   r_mem [DEPTH];
    logic [AW-1:0]  r_wptr;
    logic [AW-1:0]  r_rptr;
    logic [CW-1:0]  r_count;
    logic           r_arr_q;

    logic           w_push;
    logic           w_pop;
    logic           w_stall;
    logic           w_valid;
    fetch_entry_t   w_head;

    // Stall one entry early: the ROM read issued this cycle lands next cycle.
    assign w_stall = (r_count >= CW'(DEPTH - 1));
    assign w_valid = (r_count != '0);
    assign w_push  = r_arr_q && !bus.if_flush;
    assign w_pop   = w_valid && bus.id_ready && !bus.if_flush;
    assign w_head  = r_mem[r_rptr];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_arr_q <= 1'b0;
        end else begin
            r_arr_q <= !w_stall && !bus.if_flush;
            if (bus.if_flush) begin
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_count <= '0;
            end else begin
                if (w_push) r_wptr <= r_wptr + 1'b1;
                if (w_pop)  r_rptr <= r_rptr + 1'b1;
                r_count <= r_count + CW'(w_push) - CW'(w_pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= '{pc: bus.if_pc, inst: bus.if_inst};
    end

    assign bus.pc_stall = w_stall;
    assign bus.id_valid = w_valid;
    assign bus.id_inst  = w_valid ? w_head.inst : NOP;
    assign bus.id_pc    = w_valid ? w_head.pc   : 32'h0;
    assign bus.fb_count = r_count;

endmodule
